// File: rtl/rf_array_pkg.sv
// Shared constants and request encoding for the RF array buffer access port.
package rf_array_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 10;
  localparam int unsigned RF_DATA_WIDTH = 32;

  // Encoding lines up with the {read, write} request pair.
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WRITE      = 2'b01,
    READ       = 2'b10,
    READ_WRITE = 2'b11
  } req_kind_e;

endpackage

// File: rtl/rf_array_mem.sv
// Word storage with synchronous write, combinational read and per-word valid bits.
module rf_array_mem #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;

  // No reset on the array itself so it can map onto RAM; valid bits mask stale data.
  always_ff @(posedge clk) begin
    if (we && !reset)
      mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      valid <= '0;
    else if (we)
      valid[addr] <= 1'b1;
  end

  assign rdata  = mem[addr];
  assign rvalid = valid[addr];

endmodule

// File: rtl/rf_array_buffer_if.sv
// RISC-V facing port of the RF array buffer: request decode, write-first forwarding, registered read data.
module rf_array_buffer_if
  import rf_array_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  risc_v_read,
  input  logic                  risc_v_write,
  input  logic [ADDR_WIDTH-1:0] risc_v_addr,
  input  logic [DATA_WIDTH-1:0] risc_v_data_in,
  output logic [DATA_WIDTH-1:0] risc_v_data_out
);

  req_kind_e             req;
  logic                  write_en;
  logic                  load_out;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] next_out;

  assign req = req_kind_e'({risc_v_read, risc_v_write});

  rf_array_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .we     (write_en),
    .addr   (risc_v_addr),
    .wdata  (risc_v_data_in),
    .rdata  (mem_rdata),
    .rvalid (mem_rvalid)
  );

  always_comb begin
    write_en = 1'b0;
    load_out = 1'b0;
    next_out = risc_v_data_out;
    unique case (req)
      IDLE: ;
      WRITE: write_en = 1'b1;
      READ: begin
        load_out = 1'b1;
        next_out = mem_rvalid ? mem_rdata : '0;
      end
      READ_WRITE: begin
        write_en = 1'b1;
        load_out = 1'b1;
        next_out = risc_v_data_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      risc_v_data_out <= '0;
    else if (load_out)
      risc_v_data_out <= next_out;
  end

endmodule

// File: tb/tb_rf_array_buffer_if.sv
// Directed self-checking bench for rf_array_buffer_if with a small reference model.
module tb_rf_array_buffer_if;
  import rf_array_pkg::*;

  localparam int unsigned AW = RF_ADDR_WIDTH;
  localparam int unsigned DW = RF_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          risc_v_read;
  logic          risc_v_write;
  logic [AW-1:0] risc_v_addr;
  logic [DW-1:0] risc_v_data_in;
  logic [DW-1:0] risc_v_data_out;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  logic [DW-1:0] model_mem [1 << AW];
  logic          model_valid [1 << AW];
  logic [DW-1:0] exp_out;

  rf_array_buffer_if #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .risc_v_read     (risc_v_read),
    .risc_v_write    (risc_v_write),
    .risc_v_addr     (risc_v_addr),
    .risc_v_data_in  (risc_v_data_in),
    .risc_v_data_out (risc_v_data_out)
  );

  always #100 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    if (obs === exp)
      n_passed++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drive one request for one edge, update the model, sample 1 time unit after the edge.
  task automatic req(input req_kind_e kind, input int unsigned addr, input logic [DW-1:0] data);
    risc_v_read    = (kind == READ) || (kind == READ_WRITE);
    risc_v_write   = (kind == WRITE) || (kind == READ_WRITE);
    risc_v_addr    = AW'(addr);
    risc_v_data_in = data;
    @(posedge clk);
    if (!reset) begin
      case (kind)
        READ:       exp_out = model_valid[addr[AW-1:0]] ? model_mem[addr[AW-1:0]] : '0;
        READ_WRITE: exp_out = data;
        default:    ;
      endcase
      if (risc_v_write) begin
        model_mem[addr[AW-1:0]]   = data;
        model_valid[addr[AW-1:0]] = 1'b1;
      end
    end
    #1;
    risc_v_read  = 1'b0;
    risc_v_write = 1'b0;
  endtask

  task automatic model_reset();
    exp_out = '0;
    for (int i = 0; i < (1 << AW); i++) model_valid[i] = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    risc_v_read    = 1'b0;
    risc_v_write   = 1'b0;
    risc_v_addr    = '0;
    risc_v_data_in = '0;
    model_reset();
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_state", risc_v_data_out, 32'h0);

    // Load a nonzero value, then reset asynchronously in mid-cycle.
    req(WRITE, 10, 32'hDEADBEEF);
    req(READ, 10, '0);
    check("pre_reset_read", risc_v_data_out, 32'hDEADBEEF);
    #50 reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_immediate", risc_v_data_out, 32'h0);
    // Requests during reset must be ignored.
    req(WRITE, 4, 32'h99);
    req(READ_WRITE, 4, 32'h77);
    check("ignored_during_reset", risc_v_data_out, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req(IDLE, 0, '0);
      check("idle_after_reset", risc_v_data_out, 32'h0);
    end
    req(READ, 4, '0);
    check("no_write_in_reset", risc_v_data_out, 32'h0);
    req(READ, 10, '0);
    check("valid_cleared_10", risc_v_data_out, 32'h0);

    for (int a = 0; a < 500; a++) begin
      req(READ, a, '0);
      check("sweep_zero", risc_v_data_out, exp_out);
    end

    req(WRITE, 5, 32'h12345678);
    req(WRITE, 1023, 32'hA5A5A5A5);
    req(READ, 5, '0);
    check("read_5", risc_v_data_out, 32'h12345678);
    req(READ, 1023, '0);
    check("read_1023", risc_v_data_out, 32'hA5A5A5A5);
    req(READ, 6, '0);
    check("read_6_unwritten", risc_v_data_out, 32'h0);

    // Write-only leaves data_out untouched.
    req(WRITE, 7, 32'h1);
    check("write_holds_out", risc_v_data_out, 32'h0);
    req(READ, 7, '0);
    check("read_7_initial", risc_v_data_out, 32'h1);
    req(READ_WRITE, 7, 32'hCAFEF00D);
    check("rw_forward", risc_v_data_out, 32'hCAFEF00D);
    req(READ, 6, '0);
    req(READ, 7, '0);
    check("read_7_after_rw", risc_v_data_out, 32'hCAFEF00D);

    req(READ, 1023, '0);
    check("hold_start", risc_v_data_out, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      req(IDLE, 1023, '0);
      check("hold_idle", risc_v_data_out, 32'hA5A5A5A5);
    end

    req(WRITE, 0, 32'h0BADC0DE);
    for (int i = 1020; i < 1028; i++) begin
      req(READ, i % 1024, '0);
      check("wrap_read", risc_v_data_out, exp_out);
    end
    check("wrap_addr3_last", risc_v_data_out, 32'h0);

    req(WRITE, 3, 32'h55);
    req(READ, 3, '0);
    check("read_3_before_reset", risc_v_data_out, 32'h55);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    req(READ, 3, '0);
    check("read_3_after_reset", risc_v_data_out, 32'h0);
    req(READ, 0, '0);
    check("read_0_after_reset", risc_v_data_out, 32'h0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
